btn_event_detect: RTL and testbench

Parametrised multi-channel push-button front end for the present board: synchronises and debounces `CHANNELS` raw button/lever inputs and classifies each press as a short click, double click or long press. It replaces single-button debounce logic for inputs like `music_en`. Downstream blocks (music player, light/lamp mode control, display) consume clean levels and one-cycle event pulses instead of raw pins.

---
 rtl/present_pkg.sv | 27 ++
 rtl/btn_event_detect_if.sv | 25 ++
 rtl/btn_debounce.sv | 58 +++++
 rtl/btn_event_detect.sv | 140 ++++++++++++++
 tb/tb_btn_event_detect.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/present_pkg.sv
// Shared constants for the present board: event FSM state encoding and
// default 50 MHz timing for the push-button front end.
package present_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRESS  = 3'd1;
  localparam logic [2:0] ST_LONG   = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_PRESS2 = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_PRESS  = ST_PRESS,
    S_LONG   = ST_LONG,
    S_WAIT   = ST_WAIT,
    S_PRESS2 = ST_PRESS2
  } ev_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 500_000;     // 10 ms
  localparam int DEF_LONG_CYCLES     = 50_000_000;  // 1 s
  localparam int DEF_DCLICK_CYCLES   = 15_000_000;  // 300 ms

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_event_detect_if.sv
// Button front-end bundle: raw pins in, clean levels and event pulses out.
interface btn_event_detect_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] btn_raw;
  logic [CHANNELS-1:0] btn_level;
  logic [CHANNELS-1:0] press_pulse;
  logic [CHANNELS-1:0] release_pulse;
  logic [CHANNELS-1:0] short_pulse;
  logic [CHANNELS-1:0] double_pulse;
  logic [CHANNELS-1:0] long_pulse;
  logic [CHANNELS-1:0] hold;

  modport master (
    output btn_raw,
    input  btn_level, press_pulse, release_pulse,
    input  short_pulse, double_pulse, long_pulse, hold
  );

  modport slave (
    input  btn_raw,
    output btn_level, press_pulse, release_pulse,
    output short_pulse, double_pulse, long_pulse, hold
  );
endinterface

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser plus stability counter.
// press_evt/release_evt announce the edge that updates stable and the pulses.
module btn_debounce #(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_b,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic press_evt,
  output logic release_evt
);

  localparam logic           IDLE_LVL = ACTIVE_LOW;
  localparam int             DW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0]  DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [DW-1:0] cnt;
  logic          accept;

  assign accept      = (sync2 != stable) && (cnt == DB_LAST);
  assign press_evt   = accept && (sync2 != IDLE_LVL);
  assign release_evt = accept && (sync2 == IDLE_LVL);
  assign level       = (stable != IDLE_LVL);

  // Synchroniser and stable level reset to the idle pin level so that reset
  // never looks like a press.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sync1         <= IDLE_LVL;
      sync2         <= IDLE_LVL;
      stable        <= IDLE_LVL;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync1         <= raw;
      sync2         <= sync1;
      press_pulse   <= press_evt;
      release_pulse <= release_evt;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/btn_event_detect.sv
// Multi-channel push-button front end: debounce plus click / double-click /
// long-press classification, one independent slice per channel.
//
// state  | meaning
// IDLE   | released, no pending click
// PRESS  | first press held, timing toward long press
// LONG   | long press reported, hold asserted until release
// WAIT   | released after a click, waiting for a possible second press
// PRESS2 | second press of a double click held
module btn_event_detect
  import present_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int DCLICK_CYCLES   = DEF_DCLICK_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  btn_event_detect_if.slave  bus
);

  localparam int            TW        = $clog2(max_int(LONG_CYCLES, DCLICK_CYCLES) + 1);
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] DC_LAST   = TW'((DCLICK_CYCLES > 0) ? DCLICK_CYCLES - 1 : 0);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic          level;
    logic          press_p;
    logic          release_p;
    logic          press_evt;
    logic          release_evt;
    ev_state_t     state;
    ev_state_t     state_nx;
    logic [TW-1:0] cnt;
    logic [TW-1:0] cnt_nx;
    logic          short_nx;
    logic          double_nx;
    logic          long_nx;
    logic          short_q;
    logic          double_q;
    logic          long_q;

    btn_debounce #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk           (clk),
      .rst_b         (rst),
      .raw           (bus.btn_raw[c]),
      .level         (level),
      .press_pulse   (press_p),
      .release_pulse (release_p),
      .press_evt     (press_evt),
      .release_evt   (release_evt)
    );

    // The FSM reacts to the same edge that raises press/release pulses, so
    // short/double/long land exactly on their nominal cycles.
    always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      short_nx  = 1'b0;
      double_nx = 1'b0;
      long_nx   = 1'b0;
      unique case (state)
        S_IDLE: begin
          if (press_evt) state_nx = S_PRESS;
        end
        S_PRESS: begin
          if (release_evt) begin
            if (DCLICK_CYCLES == 0) begin
              short_nx = 1'b1;
              state_nx = S_IDLE;
            end else begin
              state_nx = S_WAIT;
            end
          end else if (cnt == LONG_LAST) begin
            long_nx  = 1'b1;
            state_nx = S_LONG;
          end else begin
            cnt_nx = cnt + TW'(1);
          end
        end
        S_LONG: begin
          if (release_evt) state_nx = S_IDLE;
        end
        S_WAIT: begin
          if (press_evt) begin
            state_nx = S_PRESS2;
          end else if (cnt == DC_LAST) begin
            short_nx = 1'b1;
            state_nx = S_IDLE;
          end else begin
            cnt_nx = cnt + TW'(1);
          end
        end
        S_PRESS2: begin
          if (release_evt) begin
            double_nx = 1'b1;
            state_nx  = S_IDLE;
          end else if (cnt == LONG_LAST) begin
            long_nx  = 1'b1;
            state_nx = S_LONG;
          end else begin
            cnt_nx = cnt + TW'(1);
          end
        end
        default: state_nx = S_IDLE;
      endcase
      if (state_nx != state) cnt_nx = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state    <= S_IDLE;
        cnt      <= '0;
        short_q  <= 1'b0;
        double_q <= 1'b0;
        long_q   <= 1'b0;
      end else begin
        state    <= state_nx;
        cnt      <= cnt_nx;
        short_q  <= short_nx;
        double_q <= double_nx;
        long_q   <= long_nx;
      end
    end

    assign bus.btn_level[c]     = level;
    assign bus.press_pulse[c]   = press_p;
    assign bus.release_pulse[c] = release_p;
    assign bus.short_pulse[c]   = short_q;
    assign bus.double_pulse[c]  = double_q;
    assign bus.long_pulse[c]    = long_q;
    assign bus.hold[c]          = (state == S_LONG);
  end

endmodule

// File: tb/tb_btn_event_detect.sv
// Directed bench for btn_event_detect: 2 channels, debounce 8, long 40,
// double-click window 20; event cycles logged by a monitor and checked.
module tb_btn_event_detect;

  localparam int CH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  int n_press[CH], n_rel[CH], n_short[CH], n_double[CH], n_long[CH], n_lvl[CH];
  int t_press[CH], t_press_prev[CH], t_rel[CH], t_rel_prev[CH];
  int t_short[CH], t_double[CH], t_long[CH], t_hold_up[CH], t_hold_dn[CH];
  logic [CH-1:0] lvl_q = '0;
  logic [CH-1:0] hold_q = '0;

  btn_event_detect_if #(.CHANNELS(CH)) bus ();

  btn_event_detect #(
    .CHANNELS        (CH),
    .ACTIVE_LOW      (1'b1),
    .DEBOUNCE_CYCLES (8),
    .LONG_CYCLES     (40),
    .DCLICK_CYCLES   (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (bus.press_pulse[c])   begin n_press[c]++;  t_press_prev[c] = t_press[c]; t_press[c] = cyc; end
      if (bus.release_pulse[c]) begin n_rel[c]++;    t_rel_prev[c] = t_rel[c];     t_rel[c] = cyc;   end
      if (bus.short_pulse[c])   begin n_short[c]++;  t_short[c] = cyc;  end
      if (bus.double_pulse[c])  begin n_double[c]++; t_double[c] = cyc; end
      if (bus.long_pulse[c])    begin n_long[c]++;   t_long[c] = cyc;   end
      if (bus.btn_level[c] != lvl_q[c]) n_lvl[c]++;
      if (bus.hold[c] && !hold_q[c]) t_hold_up[c] = cyc;
      if (!bus.hold[c] && hold_q[c]) t_hold_dn[c] = cyc;
    end
    lvl_q  = bus.btn_level;
    hold_q = bus.hold;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    for (int c = 0; c < CH; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_short[c] = 0; n_double[c] = 0;
      n_long[c] = 0;  n_lvl[c] = 0;
      t_press[c] = -1; t_press_prev[c] = -1; t_rel[c] = -1; t_rel_prev[c] = -1;
      t_short[c] = -1; t_double[c] = -1; t_long[c] = -1;
      t_hold_up[c] = -1; t_hold_dn[c] = -1;
    end
  endtask

  function automatic int all_outs();
    return int'({bus.btn_level, bus.press_pulse, bus.release_pulse, bus.short_pulse,
                 bus.double_pulse, bus.long_pulse, bus.hold});
  endfunction

  int a;

  initial begin
    clr();
    bus.btn_raw = '1;
    rst = 1'b0;
    step(3);
    chk("reset_outputs", all_outs(), 0);
    rst = 1'b1;
    step(5);
    chk("idle_after_reset", all_outs(), 0);

    // 1: bounce, then settle pressed
    clr();
    for (int i = 0; i < 8; i++) begin
      bus.btn_raw[0] = i[0];
      step(3);
    end
    bus.btn_raw[0] = 1'b0;
    a = cyc;
    step(15);
    chk("bounce_press_count", n_press[0], 1);
    chk("bounce_press_delay", t_press[0] - a, 10);
    chk("bounce_level_edges", n_lvl[0], 1);
    chk("bounce_no_release", n_rel[0], 0);
    bus.btn_raw[0] = 1'b1;
    step(60);

    // 2: short click
    clr();
    bus.btn_raw[0] = 1'b0; a = cyc;
    step(15);
    bus.btn_raw[0] = 1'b1;
    step(40);
    chk("short_press_delay", t_press[0] - a, 10);
    chk("short_count", n_short[0], 1);
    chk("short_after_release", t_short[0] - t_rel[0], 20);
    chk("short_no_double", n_double[0], 0);
    chk("short_no_long", n_long[0], 0);

    // 3: double click
    clr();
    bus.btn_raw[0] = 1'b0; step(15);
    bus.btn_raw[0] = 1'b1; step(12);
    bus.btn_raw[0] = 1'b0; step(15);
    bus.btn_raw[0] = 1'b1; step(40);
    chk("dbl_release_count", n_rel[0], 2);
    chk("dbl_count", n_double[0], 1);
    chk("dbl_with_release", t_double[0], t_rel[0]);
    chk("dbl_no_short", n_short[0], 0);
    chk("dbl_no_long", n_long[0], 0);

    // 4: long press
    clr();
    bus.btn_raw[0] = 1'b0; step(70);
    bus.btn_raw[0] = 1'b1; step(30);
    chk("long_count", n_long[0], 1);
    chk("long_after_press", t_long[0] - t_press[0], 40);
    chk("hold_rise", t_hold_up[0], t_long[0]);
    chk("hold_fall", t_hold_dn[0], t_rel[0]);
    chk("long_no_short", n_short[0], 0);
    chk("long_no_double", n_double[0], 0);
    chk("ch1_quiet", n_press[1], 0);

    // 5: reset while in PRESS
    bus.btn_raw[0] = 1'b0;
    step(20);
    chk("pre_reset_level", int'(bus.btn_level[0]), 1);
    clr();
    rst = 1'b0;
    #1;
    chk("reset_async_outs", all_outs(), 0);
    step(3);
    rst = 1'b1; a = cyc;
    step(15);
    bus.btn_raw[0] = 1'b1;
    step(40);
    chk("rst_press_delay", t_press[0] - a, 10);
    chk("rst_press_count", n_press[0], 1);
    chk("rst_short_count", n_short[0], 1);
    chk("rst_short_delay", t_short[0] - t_rel[0], 20);

    // 6: ch0 long press while ch1 double-clicks on the window-expiry cycle
    clr();
    bus.btn_raw = '0; step(15);
    bus.btn_raw[1] = 1'b1; step(20);
    bus.btn_raw[1] = 1'b0; step(15);
    bus.btn_raw[1] = 1'b1; step(20);
    bus.btn_raw[0] = 1'b1; step(40);
    chk("ind_ch0_long", n_long[0], 1);
    chk("ind_ch0_long_delay", t_long[0] - t_press[0], 40);
    chk("ind_ch0_hold_fall", t_hold_dn[0], t_rel[0]);
    chk("ind_ch0_no_short", n_short[0], 0);
    chk("ind_ch1_expiry_hit", t_press[1] - t_rel_prev[1], 20);
    chk("ind_ch1_double", n_double[1], 1);
    chk("ind_ch1_dbl_cycle", t_double[1], t_rel[1]);
    chk("ind_ch1_no_short", n_short[1], 0);
    chk("ind_ch1_no_long", n_long[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
